// File: rtl/aes_share_frontend_pkg.sv
// Shared constants, FSM encoding and share-slicing helpers for the AES share frontend.
package aes_share_frontend_pkg;

    localparam int BLK_W      = 128;
    localparam int SEED_W     = 80;
    localparam int PT_MASK_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // Key masks follow the d-1 plaintext masks inside mask_rnd.
    function automatic int key_mask_lo(input int n_sh);
        return BLK_W * (n_sh - 1);
    endfunction

    function automatic int share_lo(input int i);
        return BLK_W * i;
    endfunction

endpackage

// File: rtl/aes_share_frontend_if.sv
// Host and core side streams of the share frontend; slave is the frontend's view.
interface aes_share_frontend_if
    import aes_share_frontend_pkg::*;
#(
    parameter int d     = 2,
    parameter int CNT_W = 16
) ();

    logic                         pt_valid;
    logic                         pt_ready;
    logic [BLK_W-1:0]             pt_data;
    logic [BLK_W-1:0]             key_data;
    logic                         mask_valid;
    logic [2*BLK_W*(d-1)-1:0]     mask_rnd;
    logic                         seed_in_valid;
    logic                         seed_in_ready;
    logic [SEED_W-1:0]            seed_in;
    logic                         ct_valid;
    logic                         ct_ready;
    logic [BLK_W-1:0]             ct_data;
    logic                         core_in_valid;
    logic                         core_in_ready;
    logic [BLK_W*d-1:0]           core_shares_plaintext;
    logic [BLK_W*d-1:0]           core_shares_key;
    logic                         core_seed_valid;
    logic                         core_seed_ready;
    logic [SEED_W-1:0]            core_seed;
    logic                         core_out_valid;
    logic                         core_out_ready;
    logic [BLK_W*d-1:0]           core_shares_ciphertext;
    logic [CNT_W-1:0]             enc_count;

    modport slave (
        input  pt_valid, pt_data, key_data, mask_valid, mask_rnd,
        input  seed_in_valid, seed_in, ct_ready,
        input  core_in_ready, core_seed_ready, core_out_valid, core_shares_ciphertext,
        output pt_ready, seed_in_ready, ct_valid, ct_data,
        output core_in_valid, core_shares_plaintext, core_shares_key,
        output core_seed_valid, core_seed, core_out_ready, enc_count
    );

    modport master (
        output pt_valid, pt_data, key_data, mask_valid, mask_rnd,
        output seed_in_valid, seed_in, ct_ready,
        output core_in_ready, core_seed_ready, core_out_valid, core_shares_ciphertext,
        input  pt_ready, seed_in_ready, ct_valid, ct_data,
        input  core_in_valid, core_shares_plaintext, core_shares_key,
        input  core_seed_valid, core_seed, core_out_ready, enc_count
    );

endinterface

// File: rtl/aes_share_frontend_sh_xor_recombine.sv
// XOR-folds n 128-bit shares into one block.
module sh_xor_recombine
    import aes_share_frontend_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [BLK_W*N-1:0] shares,
    output logic [BLK_W-1:0]   value
);

    always_comb begin
        value = '0;
        for (int i = 0; i < N; i++) begin
            value = value ^ shares[share_lo(i) +: BLK_W];
        end
    end

endmodule

// File: rtl/aes_share_frontend.sv
// Host-side masking adapter for the masked AES core: shares inputs, recombines ciphertext.
//   state | meaning
//   IDLE  | accept seed (priority) or a masked block from the host
//   SEED  | present seed to core until core_seed_ready
//   SEND  | present shared pt/key to core until core_in_ready
//   WAIT  | wait for core ciphertext, stall while output buffer is full
module aes_share_frontend
    import aes_share_frontend_pkg::*;
#(
    parameter int d     = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    aes_share_frontend_if.slave bus
);

    localparam int KEY_LO = key_mask_lo(d);
    localparam int MSK_W  = BLK_W * (d - 1);

    state_t             state_q, state_d;
    logic [SEED_W-1:0]  seed_q;
    logic [BLK_W*d-1:0] pt_sh_q, key_sh_q;
    logic [BLK_W-1:0]   ct_q, ct_rec, pt_sh0, key_sh0;
    logic               ct_full_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MSK_W-1:0]   pt_mask, key_mask;
    logic               seed_rdy, pt_rdy, out_rdy;
    logic               seed_fire, pt_fire, core_seed_fire, core_out_fire;

    assign pt_mask  = bus.mask_rnd[PT_MASK_LO +: MSK_W];
    assign key_mask = bus.mask_rnd[KEY_LO +: MSK_W];

    // Share 0 is the data folded with every mask slice, so all d shares XOR back to the data.
    sh_xor_recombine #(.N(d)) u_pt_sh0  (.shares({pt_mask, bus.pt_data}),   .value(pt_sh0));
    sh_xor_recombine #(.N(d)) u_key_sh0 (.shares({key_mask, bus.key_data}), .value(key_sh0));
    sh_xor_recombine #(.N(d)) u_ct_rec  (.shares(bus.core_shares_ciphertext), .value(ct_rec));

    always_comb begin
        state_d  = state_q;
        seed_rdy = 1'b0;
        pt_rdy   = 1'b0;
        out_rdy  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                seed_rdy = bus.seed_in_valid;
                pt_rdy   = ~bus.seed_in_valid & bus.mask_valid;
                if (bus.seed_in_valid) begin
                    state_d = ST_SEED;
                end else if (bus.pt_valid && bus.mask_valid) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEED: if (bus.core_seed_ready) state_d = ST_IDLE;
            ST_SEND: if (bus.core_in_ready) state_d = ST_WAIT;
            ST_WAIT: begin
                out_rdy = ~ct_full_q | bus.ct_ready;
                if (bus.core_out_valid && out_rdy) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign seed_fire      = seed_rdy & bus.seed_in_valid;
    assign pt_fire        = pt_rdy & bus.pt_valid;
    assign core_seed_fire = (state_q == ST_SEED) & bus.core_seed_ready;
    assign core_out_fire  = out_rdy & bus.core_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            seed_q    <= '0;
            pt_sh_q   <= '0;
            key_sh_q  <= '0;
            ct_q      <= '0;
            ct_full_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (seed_fire) seed_q <= bus.seed_in;
            if (pt_fire) begin
                pt_sh_q  <= {pt_mask, pt_sh0};
                key_sh_q <= {key_mask, key_sh0};
            end
            if (core_seed_fire) begin
                cnt_q <= '0;
            end else if (core_out_fire && cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (core_out_fire) begin
                ct_q      <= ct_rec;
                ct_full_q <= 1'b1;
            end else if (bus.ct_ready) begin
                ct_full_q <= 1'b0;
            end
        end
    end

    assign bus.seed_in_ready         = seed_rdy;
    assign bus.pt_ready              = pt_rdy;
    assign bus.core_out_ready        = out_rdy;
    assign bus.core_in_valid         = (state_q == ST_SEND);
    assign bus.core_seed_valid       = (state_q == ST_SEED);
    assign bus.core_seed             = seed_q;
    assign bus.core_shares_plaintext = pt_sh_q;
    assign bus.core_shares_key       = key_sh_q;
    assign bus.ct_valid              = ct_full_q;
    assign bus.ct_data               = ct_q;
    assign bus.enc_count             = cnt_q;

endmodule

// File: doc/aes_share_frontend.md
# aes_share_frontend

Host-side adapter for the masked 32-bit AES-128 encryption core. It accepts unmasked plaintext/key blocks and PRNG seeds from a host over valid/ready streams and splits plaintext/key into `d` Boolean shares using externally supplied fresh randomness. It drives the core's shared SVRS input and seed streams, consumes the core's shared ciphertext, and returns the recombined ciphertext to the host. It is the transmitter/receiver counterpart of the core top-level interface and sits between the host bus and the core, on the same clock and reset.

## Interface
- `d`, 2, number of shares (d ≥ 2 required)
- `CNT_W`, 16, width of encryptions-since-reseed counter
- `clk` in 1 clock
- `rst` in 1 reset, synchronous, active-high; clock `clk`
- `pt_valid` in 1 / `pt_ready` out 1: host block stream handshake
- `pt_data` in 128 plaintext, `key_data` in 128 key (unmasked)
- `mask_valid` in 1: `mask_rnd` holds fresh randomness this cycle
- `mask_rnd` in 256*(d-1): plaintext share j (1..d-1) at `[128*(j-1) +: 128]`; key share j at `[128*(d-1)+128*(j-1) +: 128]`
- `seed_in_valid` in 1 / `seed_in_ready` out 1 / `seed_in` in 80: host seed stream
- `ct_valid` out 1 / `ct_ready` in 1 / `ct_data` out 128: host ciphertext stream
- `core_in_valid` out 1 / `core_in_ready` in 1
- `core_shares_plaintext`, `core_shares_key` out 128*d: share i at `[128*i +: 128]`
- `core_seed_valid` out 1 / `core_seed_ready` in 1 / `core_seed` out 80
- `core_out_valid` in 1 / `core_out_ready` out 1 / `core_shares_ciphertext` in 128*d
- `enc_count` out CNT_W: encryptions completed since last reseed, saturating

## Operation
- FSM states IDLE, SEED, SEND, WAIT; reset → IDLE.
- IDLE: seed has priority. `seed_in_ready = IDLE & seed_in_valid`; on that transfer seed register ← `seed_in`, → SEED.
- IDLE, no seed request: `pt_ready = IDLE & ~seed_in_valid & mask_valid`. On transfer: share j ← mask slice j (j ≥ 1); share 0 ← data XOR all mask slices (for both plaintext and key); → SEND.
- SEED: `core_seed_valid = 1`, `core_seed` stable; on `core_seed_ready` → IDLE, `enc_count` ← 0.
- SEND: `core_in_valid = 1`, share registers stable; on `core_in_ready` → WAIT.
- WAIT: `core_out_ready = ~ct_full | ct_ready`; on core transfer `ct_data` ← XOR of all d ciphertext shares, `ct_full` ← 1, `enc_count` saturating +1, → IDLE.
- `core_out_ready` is 0 outside WAIT. `ct_valid = ct_full`; cleared on `ct_ready` unless reloaded in the same cycle.
- Reseed is never started with an encryption outstanding (SEED reachable only from IDLE), and `core_in_valid` is never asserted in SEED, which satisfies the core's reseed precondition.
- Host may submit the next block while the previous ciphertext is still held in `ct_data`.

## Timing
- Reset values: all handshake outputs 0, `ct_data`, share/seed registers 0, `enc_count` 0, state IDLE.
- `pt_ready`, `seed_in_ready`, `core_out_ready` are combinational from state/inputs; all other outputs are registered.
- Host block accepted at cycle t → `core_in_valid` high at t+1.
- Core ciphertext transfer at t → `ct_valid` high at t+1.
- Simultaneous `seed_in_valid` and `pt_valid` in IDLE: seed wins, `pt_ready` = 0.
- `mask_valid` low in IDLE: no block accepted, even if `pt_valid` is high.
- `ct_full` with `ct_ready` and core transfer in the same cycle: new value loaded, `ct_valid` stays 1.
- `enc_count` at all-ones stays all-ones.
- Reset mid-operation: immediate return to IDLE with reset values. The core shares `rst`, so no transaction survives.

## Structure
- Shared package holds the FSM state encoding, `BLK_W=128`, `SEED_W=80`, and the share-slicing index constants.
- One sub-module, `sh_xor_recombine` (d×128 → 128 XOR), instantiated for ciphertext recombination and reused for share-0 generation.

## Test plan
- FIPS-197 vector with d=2: key `000102…0f`, pt `00112233445566778899aabbccddeeff`, random masks → `ct_data = 69c4e0d86a7b0430d8cdb78070b4c55a`. Core input share XOR equals pt/key, and share 1 equals the mask slice.
- Seed `0x0123456789abcdef0123` with `core_seed_ready` delayed 5 cycles → `core_seed` stable and valid for 5 cycles, then returns to IDLE and `enc_count` = 0.
- `seed_in_valid` and `pt_valid` high together in IDLE → seed taken first, block accepted only after SEED completes.
- `ct_ready` held low across 2 encryptions → second core output stalled (`core_out_ready` = 0) until the first ciphertext drains; no data lost.
- `mask_valid` = 0 for 3 cycles while `pt_valid` = 1 → `pt_ready` = 0 throughout; block accepted on the first `mask_valid` cycle.
- Reset asserted in WAIT → next cycle state IDLE, all outputs at reset values, `enc_count` = 0.
